// File: rtl/cprv_pkg.sv
// Shared types and constants for the cprv pipeline's data-memory interface.
package cprv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [63:0] DMEM_RESP_STORE_DATA = 64'h0;

  // Encoding of w_en on the dmem request channel.
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam int unsigned DMEM_LATENCY_MAX = 15;

  function automatic logic [3:0] dmem_wait_init(input int unsigned latency);
    return 4'(latency - 1);
  endfunction

endpackage

// File: rtl/cprv_dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_WIDTH. Contents are never reset;
// rdata only updates on a read so it holds the last load result.
module cprv_dmem_array #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [1 << DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cprv_dmem_responder.sv
// Data-memory responder: accepts one dmem request at a time, performs it on the
// internal array and returns one response after LATENCY cycles.
module cprv_dmem_responder
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_dmem_i,
  output logic                  ready_dmem_o,
  input  logic [DATA_WIDTH-1:0] addr_dmem_i,
  input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
  input  logic                  w_en_dmem_i,
  output logic                  valid_mem_dmem_o,
  input  logic                  ready_mem_dmem_i,
  output logic [DATA_WIDTH-1:0] rdata_dmem_o
);

  if (LATENCY < 1 || LATENCY > int'(DMEM_LATENCY_MAX)) begin : g_latency_illegal
    $fatal(1, "cprv_dmem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_LOG2 + 3 > DATA_WIDTH) begin : g_depth_illegal
    $fatal(1, "cprv_dmem_responder: DEPTH_LOG2 too large for DATA_WIDTH");
  end

  localparam logic [3:0] WAIT_INIT = dmem_wait_init(LATENCY);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  w_en_q, w_en_d;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  unused_addr;

  // Word addressing: byte offset and bits above the array depth are dropped.
  assign idx         = addr_dmem_i[DEPTH_LOG2+2:3];
  assign unused_addr = ^{addr_dmem_i[DATA_WIDTH-1:DEPTH_LOG2+3], addr_dmem_i[2:0]};

  assign ready_dmem_o     = (state_q == IDLE) || ((state_q == RESP) && ready_mem_dmem_i);
  assign accept           = valid_dmem_i && ready_dmem_o;
  assign valid_mem_dmem_o = (state_q == RESP);
  assign rdata_dmem_o     = ((state_q == RESP) && (w_en_q == OP_LOAD)) ?
                            arr_rdata : DATA_WIDTH'(DMEM_RESP_STORE_DATA);

  cprv_dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .en_i    (accept),
    .we_i    (w_en_dmem_i == OP_STORE),
    .idx_i   (idx),
    .wdata_i (wdata_dmem_i),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_en_d  = w_en_q;

    case (state_q)
      IDLE: ;
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (ready_mem_dmem_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new acceptance overrides the retire-to-IDLE above (back-to-back).
    if (accept) begin
      w_en_d = w_en_dmem_i;
      if (LATENCY == 1) begin
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = WAIT_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      w_en_q  <= OP_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_en_q  <= w_en_d;
    end
  end

endmodule

// File: tb/tb_cprv_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 1 and 4) driven with directed and
// random requests, responses checked against an array model of memory.
module tb_cprv_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic        req_v   [2];
  logic        req_rdy [2];
  logic [63:0] req_addr[2];
  logic [63:0] req_wd  [2];
  logic        req_we  [2];
  logic        rsp_v   [2];
  logic        rsp_rdy [2];
  logic [63:0] rsp_d   [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [63:0] mem_m [2][1024];
  bit          wr_m  [2][1024];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cprv_dmem_responder #(.DATA_WIDTH(64), .DEPTH_LOG2(10), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .valid_dmem_i(req_v[0]), .ready_dmem_o(req_rdy[0]),
    .addr_dmem_i(req_addr[0]), .wdata_dmem_i(req_wd[0]), .w_en_dmem_i(req_we[0]),
    .valid_mem_dmem_o(rsp_v[0]), .ready_mem_dmem_i(rsp_rdy[0]), .rdata_dmem_o(rsp_d[0])
  );

  cprv_dmem_responder #(.DATA_WIDTH(64), .DEPTH_LOG2(10), .LATENCY(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .valid_dmem_i(req_v[1]), .ready_dmem_o(req_rdy[1]),
    .addr_dmem_i(req_addr[1]), .wdata_dmem_i(req_wd[1]), .w_en_dmem_i(req_we[1]),
    .valid_mem_dmem_o(rsp_v[1]), .ready_mem_dmem_i(rsp_rdy[1]), .rdata_dmem_o(rsp_d[1])
  );

  function automatic int widx(input logic [63:0] a);
    return int'(a[12:3]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (rsp_v[s] && rsp_rdy[s]) begin
          if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp%0d unexpected: got %h, required no response", s, rsp_d[s]);
          end else begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("rsp%0d data", s), rsp_d[s], e);
          end
        end
      end
    end
  endtask

  // Presents a request and returns #1 after its acceptance edge with valid dropped.
  task automatic issue(input int s, input logic we, input logic [63:0] a, input logic [63:0] d,
                       output int waited);
    int n;
    int wi;
    n = 0;
    req_v[s] = 1'b1; req_we[s] = we; req_addr[s] = a; req_wd[s] = d;
    @(negedge clk);
    while (!req_rdy[s] && n < 200) begin
      n++;
      if (n >= 3) begin
        @(posedge clk); #1;
        rsp_rdy[s] = 1'b1;
      end
      @(negedge clk);
    end
    waited = n;
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL accept timeout dut%0d: got no ready, required ready within 200 cycles", s);
      req_v[s] = 1'b0;
      return;
    end
    wi = widx(a);
    if (we) begin
      mem_m[s][wi] = d;
      wr_m[s][wi]  = 1'b1;
      if (s == 0) q0.push_back(64'h0); else q1.push_back(64'h0);
    end else begin
      if (s == 0) q0.push_back(mem_m[s][wi]); else q1.push_back(mem_m[s][wi]);
    end
    @(posedge clk); #1;
    req_v[s] = 1'b0;
  endtask

  task automatic rand_phase(input int s, input int count);
    int w;
    int wi;
    logic [63:0] a;
    logic we;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      rsp_rdy[s] = ($urandom_range(0, 3) != 0);
      a = {32'($urandom), 32'($urandom)};
      wi = $urandom_range(0, 63);
      a[12:3] = 10'(wi);
      we = $urandom_range(0, 1) == 1 || !wr_m[s][wi];
      issue(s, we, a, {32'($urandom), 32'($urandom)}, w);
    end
    rsp_rdy[s] = 1'b1;
  endtask

  initial begin
    int w;
    int c0;
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; req_v[s] = 1'b0; req_we[s] = 1'b0;
      req_addr[s] = '0; req_wd[s] = '0; rsp_rdy[s] = 1'b1;
    end
    fork monitor(); join_none

    #3;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset valid%0d", s), 64'(rsp_v[s]), 64'h0);
      chk($sformatf("reset rdata%0d", s), rsp_d[s], 64'h0);
      chk($sformatf("reset ready%0d", s), 64'(req_rdy[s]), 64'h1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // Store then load, LATENCY=1
    issue(0, 1'b1, 64'h40, 64'hDEAD_BEEF_0123_4567, w);
    chk("store latency1 valid", 64'(rsp_v[0]), 64'h1);
    issue(0, 1'b0, 64'h40, 64'h0, w);
    chk("load latency1 valid", 64'(rsp_v[0]), 64'h1);

    // Aliasing
    issue(0, 1'b1, 64'h2000, 64'h1, w);
    issue(0, 1'b0, 64'h0, 64'h0, w);
    issue(0, 1'b0, 64'h43, 64'h0, w);

    // Backpressure on a load of 0x40
    @(posedge clk); #1;
    rsp_rdy[0] = 1'b0;
    issue(0, 1'b0, 64'h40, 64'h0, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp valid held", 64'(rsp_v[0]), 64'h1);
      chk("bp rdata stable", rsp_d[0], 64'hDEAD_BEEF_0123_4567);
      chk("bp ready low", 64'(req_rdy[0]), 64'h0);
    end
    @(posedge clk); #1;
    rsp_rdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp retired", 64'(rsp_v[0]), 64'h0);

    // Throughput: 4 store/load pairs back to back
    @(posedge clk); #1;
    c0 = cyc;
    for (int p = 0; p < 4; p++) begin
      issue(0, 1'b1, 64'(p * 16), 64'hA5A5_0000_0000_0000 | 64'(p), w);
      issue(0, 1'b0, 64'(p * 16), 64'h0, w);
    end
    chk("throughput cycles", 64'(cyc - c0), 64'd8);

    rand_phase(0, 300);

    // LATENCY=4 timing
    issue(1, 1'b1, 64'h100, 64'h1234_5678_9ABC_DEF0, w);
    issue(1, 1'b0, 64'h100, 64'h0, w);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k < 4) begin
        chk($sformatf("lat4 ready t+%0d", k), 64'(req_rdy[1]), 64'h0);
        chk($sformatf("lat4 valid t+%0d", k), 64'(rsp_v[1]), 64'h0);
      end else begin
        chk("lat4 valid t+4", 64'(rsp_v[1]), 64'h1);
      end
    end

    // Reset mid-WAIT drops the response but keeps the store
    @(posedge clk); #1;
    issue(1, 1'b1, 64'h80, 64'hAA, w);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    q1.delete();
    #1;
    chk("rst mid-wait valid", 64'(rsp_v[1]), 64'h0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst release ready", 64'(req_rdy[1]), 64'h1);
    chk("rst release valid", 64'(rsp_v[1]), 64'h0);
    issue(1, 1'b0, 64'h80, 64'h0, w);

    rand_phase(1, 100);

    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain q0", 64'(q0.size()), 64'h0);
    chk("drain q1", 64'(q1.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
